booth_mult_r4_hs: RTL and testbench



---
 rtl/booth_mult_r4_hs_if.sv | 30 +++
 rtl/booth_mult_r4_hs.sv | 75 +++++++
 tb/tb_booth_mult_r4_hs.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/booth_mult_r4_hs_if.sv
// booth_mult_r4_hs_if: operand/result handshake bundle for booth_mult_r4_hs.
// Carries in_acc only when BOOTH_MULT_ACC_EN is defined.
interface booth_mult_r4_hs_if #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [A_WIDTH-1:0]         in_a;
  logic [B_WIDTH-1:0]         in_b;
  logic                       in_signed;
`ifdef BOOTH_MULT_ACC_EN
  logic [A_WIDTH+B_WIDTH-1:0] in_acc;
`endif
  logic                       out_valid;
  logic                       out_ready;
  logic [A_WIDTH+B_WIDTH-1:0] p;
  logic                       busy;
`ifdef BOOTH_MULT_ACC_EN
  modport master (output in_valid, in_a, in_b, in_signed, in_acc, out_ready,
                  input in_ready, out_valid, p, busy);
  modport slave  (input in_valid, in_a, in_b, in_signed, in_acc, out_ready,
                  output in_ready, out_valid, p, busy);
`else
  modport master (output in_valid, in_a, in_b, in_signed, out_ready,
                  input in_ready, out_valid, p, busy);
  modport slave  (input in_valid, in_a, in_b, in_signed, out_ready,
                  output in_ready, out_valid, p, busy);
`endif
endinterface

// File: rtl/booth_mult_r4_hs.sv
// booth_mult_r4_hs: radix-4 Booth sequential multiplier, one digit per clock, valid/ready handshakes.
// BOOTH_MULT_ACC_EN adds an in_acc addend seeded into the accumulator.
module booth_mult_r4_hs #(
  parameter int A_WIDTH = 8,
  parameter int B_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  booth_mult_r4_hs_if.slave bus
);
  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int NSTEP = (B_WIDTH + 2) / 2;
  localparam int BW = 2 * NSTEP;
  localparam int AW = A_WIDTH + 2;
  localparam int SW = P_WIDTH + 2;
  localparam int CW = $clog2(NSTEP + 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [AW-1:0] a_q;
  logic [BW:0] b_q;
  logic [SW-1:0] acc_q, a_ext, sel, term, acc_nx, seed;
  logic [CW-1:0] cnt;
  logic [P_WIDTH-1:0] p_q;
  logic [2:0] win;
  logic accept, last, neg, one, two;
  assign win = b_q[2:0];
  assign neg = win[2];
  assign one = win[0] ^ win[1];
  assign two = (win == 3'b011) | (win == 3'b100);
  assign a_ext = {{(SW-AW){a_q[AW-1]}}, a_q};
  assign sel = one ? a_ext : two ? a_ext << 1 : '0;
  assign term = sel << {cnt, 1'b0};
  // Negative digits add the one's complement plus a carry-in.
  assign acc_nx = acc_q + (neg ? ~term : term) + SW'(neg);
  assign last = cnt == CW'(NSTEP - 1);
`ifdef BOOTH_MULT_ACC_EN
  assign seed = {2'b00, bus.in_acc};
`else
  assign seed = '0;
`endif
  assign bus.in_ready = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign bus.busy = state == CALC;
  assign bus.out_valid = state == DONE;
  assign bus.p = p_q;
  assign accept = bus.in_valid & bus.in_ready;
  always_comb begin
    state_nx = state;
    if (state == IDLE) state_nx = bus.in_valid ? CALC : IDLE;
    else if (state == CALC) state_nx = last ? DONE : CALC;
    else if (bus.out_ready) state_nx = bus.in_valid ? CALC : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt <= '0;
      p_q <= '0;
    end else if (accept) begin
      a_q <= {{2{bus.in_signed & bus.in_a[A_WIDTH-1]}}, bus.in_a};
      b_q <= {{(BW-B_WIDTH){bus.in_signed & bus.in_b[B_WIDTH-1]}}, bus.in_b, 1'b0};
      acc_q <= seed;
      cnt <= '0;
    end else if (state == CALC) begin
      acc_q <= acc_nx;
      b_q <= b_q >> 2;
      cnt <= cnt + 1'b1;
      if (last) p_q <= acc_nx[P_WIDTH-1:0];
    end
  end
endmodule

// File: tb/tb_booth_mult_r4_hs.sv
// tb_booth_mult_r4_hs: directed vector table plus backpressure, back-to-back and reset sequences.
module tb_booth_mult_r4_hs;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;
  booth_mult_r4_hs_if #(.A_WIDTH(8), .B_WIDTH(8)) bus ();
  booth_mult_r4_hs #(.A_WIDTH(8), .B_WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        s;
    logic [15:0] acc;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl[$];
  vec_t ops[10];
  int n_vec = 0;
  int n_err = 0;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [7:0] a, input logic [7:0] b, input logic s,
                              input logic [15:0] acc, input logic [15:0] exp);
    vec_t v;
    v.a = a; v.b = b; v.s = s; v.acc = acc; v.exp = exp;
    return v;
  endfunction
  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic s);
    longint x, y;
    x = s ? longint'($signed(a)) : longint'(a);
    y = s ? longint'($signed(b)) : longint'(b);
    return 16'(x * y);
  endfunction
  task automatic drive(input vec_t v);
    bus.in_a = v.a;
    bus.in_b = v.b;
    bus.in_signed = v.s;
`ifdef BOOTH_MULT_ACC_EN
    bus.in_acc = v.acc;
`endif
  endtask
  task automatic wait_ready();
    int t = 0;
    while (!bus.in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
  endtask
  task automatic wait_done(output int t);
    t = 0;
    while (!bus.out_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
  endtask
  task automatic run_op(input vec_t v, input string nm);
    int t;
    drive(v);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    wait_ready();
    check({nm, " in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    drive(~v);
    wait_done(t);
    check({nm, " latency"}, 32'(t), 32'd5);
    check({nm, " p"}, 32'(bus.p), 32'(v.exp));
    @(negedge clk);
    check({nm, " idle p hold"}, {15'd0, bus.out_valid, bus.p}, {16'd0, v.exp});
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int t;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    drive('0);
    #2 rst_n = 1'b0;
    #10;
    check("reset in_ready", 32'(bus.in_ready), 32'd1);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset p", 32'(bus.p), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tbl.push_back(mk(8'h80, 8'h80, 1'b1, 16'h0, 16'h4000));
    tbl.push_back(mk(8'hFF, 8'h7F, 1'b1, 16'h0, 16'hFF81));
    tbl.push_back(mk(8'hFF, 8'hFF, 1'b0, 16'h0, 16'hFE01));
    tbl.push_back(mk(8'hFF, 8'hFF, 1'b1, 16'h0, 16'h0001));
    tbl.push_back(mk(8'h03, 8'h04, 1'b0, 16'h0, 16'h000C));
    tbl.push_back(mk(8'h7F, 8'h7F, 1'b1, 16'h0, 16'h3F01));
    tbl.push_back(mk(8'h7F, 8'h80, 1'b1, 16'h0, 16'hC080));
    tbl.push_back(mk(8'h80, 8'h80, 1'b0, 16'h0, 16'h4000));
    tbl.push_back(mk(8'h00, 8'hAB, 1'b0, 16'h0, 16'h0000));
    tbl.push_back(mk(8'hFE, 8'h03, 1'b1, 16'h0, 16'hFFFA));
    tbl.push_back(mk(8'hAB, 8'h00, 1'b1, 16'h0, 16'h0000));
    tbl.push_back(mk(8'd200, 8'd100, 1'b0, 16'h0, 16'h4E20));
`ifdef BOOTH_MULT_ACC_EN
    tbl.push_back(mk(8'h03, 8'h04, 1'b0, 16'd100, 16'd112));
    tbl.push_back(mk(8'hFE, 8'h03, 1'b1, 16'h0001, 16'hFFFB));
`endif
    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));
    drive(mk(8'd3, 8'd4, 1'b0, 16'h0, 16'h0));
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    wait_done(t);
    check("bp p", 32'(bus.p), 32'd12);
    for (int i = 0; i < 4; i++) begin
      drive(mk(8'd9, 8'd9, 1'b0, 16'h0, 16'h0));
      bus.in_valid = 1'b1;
      #1;
      check("bp in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
      check("bp hold", {15'd0, bus.out_valid, bus.p}, {16'd1, 16'd12});
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    check("bp idle", {14'd0, bus.in_ready, bus.out_valid, bus.p}, {16'h2, 16'd12});
    for (int i = 0; i < 10; i++) begin
      logic [7:0] a, b;
      logic s;
      a = (i == 2) ? 8'h00 : 8'($urandom_range(0, 255));
      b = (i == 5) ? 8'h00 : 8'($urandom_range(0, 255));
      s = 1'($urandom_range(0, 1));
      if (i == 9) begin a = 8'h12; b = 8'h34; s = 1'b0; end
      ops[i] = mk(a, b, s, 16'h0, ref_mul(a, b, s));
    end
    bus.out_ready = 1'b1;
    drive(ops[0]);
    bus.in_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      wait_ready();
      check("b2b in_ready", 32'(bus.in_ready), 32'd1);
      if (j > 0) begin
        check("b2b out_valid", 32'(bus.out_valid), 32'd1);
        check($sformatf("b2b p%0d", j - 1), 32'(bus.p), 32'(ops[j-1].exp));
      end
      @(negedge clk);
      if (j < 9) drive(ops[j+1]);
      else bus.in_valid = 1'b0;
    end
    wait_done(t);
    check("b2b p9", 32'(bus.p), 32'(ops[9].exp));
    @(negedge clk);
    drive(mk(8'h55, 8'h33, 1'b0, 16'h0, 16'h0));
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst pre busy", 32'(bus.busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst mid busy", 32'(bus.busy), 32'd0);
    check("rst mid out_valid", 32'(bus.out_valid), 32'd0);
    check("rst mid p", 32'(bus.p), 32'd0);
    check("rst mid in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(mk(8'd3, 8'd4, 1'b0, 16'h0, 16'd12), "post-reset");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
